// File: rtl/decode_fetch_queue.sv
// Decode fetch queue: a circular buffer of {instr, pc} entries between fetch and decode.
// Fetch groups are compacted on enqueue, and up to four of the oldest entries are presented to the decoder.
module decode_fetch_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fq_in_valid,
  input  logic [3:0]               fq_in_mask,
  input  logic [31:0]              fq_in_instr_0,
  input  logic [31:0]              fq_in_instr_1,
  input  logic [31:0]              fq_in_instr_2,
  input  logic [31:0]              fq_in_instr_3,
  input  logic [31:0]              fq_in_pc,
  output logic                     fq_ready,
  output logic [31:0]              dec_instr_0,
  output logic [31:0]              dec_instr_1,
  output logic [31:0]              dec_instr_2,
  output logic [31:0]              dec_instr_3,
  output logic [31:0]              dec_pc_0,
  output logic [31:0]              dec_pc_1,
  output logic [31:0]              dec_pc_2,
  output logic [31:0]              dec_pc_3,
  output logic [3:0]               dec_valid,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - WIDTH);

  logic [AW-1:0] head, tail, head_next, tail_next;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] n_in, n_out;
  logic          enq, deq;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic [31:0]   in_instr  [WIDTH];
  logic [AW-1:0] wr_addr   [WIDTH];
  logic [31:0]   rd_instr  [WIDTH];
  logic [31:0]   rd_pc     [WIDTH];

  assign in_instr[0] = fq_in_instr_0;
  assign in_instr[1] = fq_in_instr_1;
  assign in_instr[2] = fq_in_instr_2;
  assign in_instr[3] = fq_in_instr_3;

  // Ready depends only on the registered count, so it never waits on the decoder.
  assign fq_ready = (count <= READY_LIMIT);
  assign enq      = fq_in_valid && fq_ready;
  assign deq      = dec_ready && dec_valid[0];

  // Each set mask bit gets the next free entry after those of the older set slots.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr_addr[i] = tail + n_in[AW-1:0];
      n_in       = n_in + CW'(fq_in_mask[i]);
    end
  end

  always_comb begin
    dec_valid = '0;
    n_out     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_valid[i] = (count > CW'(i));
      rd_instr[i]  = dec_valid[i] ? mem_instr[head + AW'(i)] : '0;
      rd_pc[i]     = dec_valid[i] ? mem_pc[head + AW'(i)]    : '0;
      n_out        = n_out + CW'(dec_valid[i]);
    end
  end

  always_comb begin
    head_next  = deq ? head + n_out[AW-1:0] : head;
    tail_next  = enq ? tail + n_in[AW-1:0]  : tail;
    count_next = count + (enq ? n_in : '0) - (deq ? n_out : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Storage is left unreset; presentation gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (fq_in_mask[i]) begin
          mem_instr[wr_addr[i]] <= in_instr[i];
          mem_pc[wr_addr[i]]    <= fq_in_pc + 32'(4 * i);
        end
      end
    end
  end

  assign dec_instr_0 = rd_instr[0];
  assign dec_instr_1 = rd_instr[1];
  assign dec_instr_2 = rd_instr[2];
  assign dec_instr_3 = rd_instr[3];
  assign dec_pc_0    = rd_pc[0];
  assign dec_pc_1    = rd_pc[1];
  assign dec_pc_2    = rd_pc[2];
  assign dec_pc_3    = rd_pc[3];
  assign fq_count    = count;

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Bench for decode_fetch_queue: directed corner cases plus random traffic.
// Every cycle, a queue-level reference model is compared against the decoder-facing outputs.
module tb_decode_fetch_queue;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fq_in_valid;
  logic [3:0]  fq_in_mask;
  logic [31:0] fq_in_instr [4];
  logic [31:0] fq_in_pc;
  logic        fq_ready;
  logic [31:0] dec_instr_0, dec_instr_1, dec_instr_2, dec_instr_3;
  logic [31:0] dec_pc_0, dec_pc_1, dec_pc_2, dec_pc_3;
  logic [3:0]  dec_valid;
  logic        dec_ready;
  logic [4:0]  fq_count;

  logic [31:0] dec_instr [4];
  logic [31:0] dec_pc    [4];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_q [$];
  bit          model_accept;
  int          model_take;
  int          mon_n;
  logic [31:0] mon_instr, mon_pc;

  decode_fetch_queue #(.DEPTH(DEPTH), .WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .fq_in_valid   (fq_in_valid),
    .fq_in_mask    (fq_in_mask),
    .fq_in_instr_0 (fq_in_instr[0]),
    .fq_in_instr_1 (fq_in_instr[1]),
    .fq_in_instr_2 (fq_in_instr[2]),
    .fq_in_instr_3 (fq_in_instr[3]),
    .fq_in_pc      (fq_in_pc),
    .fq_ready      (fq_ready),
    .dec_instr_0   (dec_instr_0),
    .dec_instr_1   (dec_instr_1),
    .dec_instr_2   (dec_instr_2),
    .dec_instr_3   (dec_instr_3),
    .dec_pc_0      (dec_pc_0),
    .dec_pc_1      (dec_pc_1),
    .dec_pc_2      (dec_pc_2),
    .dec_pc_3      (dec_pc_3),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .fq_count      (fq_count)
  );

  assign dec_instr[0] = dec_instr_0;
  assign dec_instr[1] = dec_instr_1;
  assign dec_instr[2] = dec_instr_2;
  assign dec_instr[3] = dec_instr_3;
  assign dec_pc[0]    = dec_pc_0;
  assign dec_pc[1]    = dec_pc_1;
  assign dec_pc[2]    = dec_pc_2;
  assign dec_pc[3]    = dec_pc_3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] m, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    fq_in_valid = v;
    fq_in_mask  = m;
    fq_in_pc    = pc;
    dec_ready   = rdy;
    flush       = fl;
    for (int i = 0; i < 4; i++) fq_in_instr[i] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic drainQueue();
    for (int c = 0; c < 20 && model_q.size() > 0; c++) applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_count", 32'(fq_count), 32'd0);
  endtask

  // Reference model: an ordered list of {instr, pc}; the decoder sees up to four entries from the front.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      model_accept = fq_in_valid && (model_q.size() <= DEPTH - 4);
      if (dec_ready && model_q.size() > 0) begin
        model_take = (model_q.size() > 4) ? 4 : model_q.size();
        repeat (model_take) void'(model_q.pop_front());
      end
      if (model_accept)
        for (int i = 0; i < 4; i++)
          if (fq_in_mask[i]) model_q.push_back({fq_in_instr[i], fq_in_pc + 32'(4 * i)});
    end
  end

  // The monitor compares everything the decoder sees against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fq_count > 5'(DEPTH)) begin
        $display("[TB] FAIL fq_count_bound: got %0d, expected <= %0d", fq_count, DEPTH);
        $fatal(1, "[TB] occupancy out of range");
      end
      mon_n = (model_q.size() > 4) ? 4 : model_q.size();
      checkOutput("mon_dec_valid", 32'(dec_valid), 32'((1 << mon_n) - 1));
      checkOutput("mon_fq_count", 32'(fq_count), 32'(model_q.size()));
      checkOutput("mon_fq_ready", 32'(fq_ready), (model_q.size() <= DEPTH - 4) ? 32'd1 : 32'd0);
      for (int s = 0; s < 4; s++) begin
        mon_instr = 32'h0;
        mon_pc    = 32'h0;
        if (s < model_q.size()) begin
          mon_instr = model_q[s][63:32];
          mon_pc    = model_q[s][31:0];
        end
        checkOutput($sformatf("mon_dec_instr_%0d", s), dec_instr[s], mon_instr);
        checkOutput($sformatf("mon_dec_pc_%0d", s), dec_pc[s], mon_pc);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    fq_in_valid = 1'b0;
    fq_in_mask  = 4'b0000;
    fq_in_pc    = 32'h0;
    dec_ready   = 1'b0;
    for (int i = 0; i < 4; i++) fq_in_instr[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("reset_fq_count", 32'(fq_count), 32'h0);
    checkOutput("reset_fq_ready", 32'(fq_ready), 32'h1);
    checkOutput("reset_dec_pc_0", dec_pc_0, 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 4'b1111, 32'h1c000000, 1'b0, 1'b0);
    checkOutput("full_group_valid", 32'(dec_valid), 32'hf);
    checkOutput("full_group_pc_0", dec_pc_0, 32'h1c000000);
    checkOutput("full_group_pc_3", dec_pc_3, 32'h1c00000c);
    checkOutput("full_group_instr_2", dec_instr_2, fq_in_instr[2]);
    checkOutput("full_group_count", 32'(fq_count), 32'd4);
    drainQueue();

    applyStimulus(1'b1, 4'b1010, 32'h100, 1'b0, 1'b0);
    checkOutput("holes_valid", 32'(dec_valid), 32'h3);
    checkOutput("holes_pc_0", dec_pc_0, 32'h104);
    checkOutput("holes_pc_1", dec_pc_1, 32'h10c);
    checkOutput("holes_instr_1", dec_instr_1, fq_in_instr[3]);
    checkOutput("holes_count", 32'(fq_count), 32'd2);
    drainQueue();

    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b1, 4'b1111, 32'h4000 + 32'(16 * g), 1'b0, 1'b0);
      if (g == 2) checkOutput("fill_ready_at_12", 32'(fq_ready), 32'h1);
    end
    checkOutput("fill_count_16", 32'(fq_count), 32'd16);
    checkOutput("fill_ready_low", 32'(fq_ready), 32'h0);
    applyStimulus(1'b1, 4'b1111, 32'h9000, 1'b0, 1'b0);
    checkOutput("fill_ignored_count", 32'(fq_count), 32'd16);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    checkOutput("fill_after_deq_count", 32'(fq_count), 32'd12);
    checkOutput("fill_after_deq_ready", 32'(fq_ready), 32'h1);
    drainQueue();

    applyStimulus(1'b1, 4'b0111, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 32'h2000, 1'b1, 1'b0);
    checkOutput("enq_deq_count", 32'(fq_count), 32'd4);
    checkOutput("enq_deq_valid", 32'(dec_valid), 32'hf);
    checkOutput("enq_deq_pc_0", dec_pc_0, 32'h2000);
    checkOutput("enq_deq_pc_3", dec_pc_3, 32'h200c);
    drainQueue();

    for (int n = 0; n < 40; n++)
      applyStimulus(1'b1, 4'($urandom), $urandom & 32'hffff_fffc, ($urandom_range(0, 2) != 0), 1'b0);
    drainQueue();

    applyStimulus(1'b1, 4'b1111, 32'h800, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 32'h810, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0011, 32'h820, 1'b0, 1'b0);
    checkOutput("preflush_count", 32'(fq_count), 32'd10);
    applyStimulus(1'b1, 4'b1111, 32'hdead0000, 1'b1, 1'b1);
    checkOutput("flush_count", 32'(fq_count), 32'd0);
    checkOutput("flush_valid", 32'(dec_valid), 32'h0);
    checkOutput("flush_ready", 32'(fq_ready), 32'h1);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0001, 32'h500, 1'b0, 1'b0);
    checkOutput("postflush_pc_0", dec_pc_0, 32'h500);
    checkOutput("postflush_count", 32'(fq_count), 32'd1);

    applyStimulus(1'b1, 4'b1111, 32'h600, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_count", 32'(fq_count), 32'd0);
    checkOutput("midreset_valid", 32'(dec_valid), 32'h0);
    checkOutput("midreset_pc_0", dec_pc_0, 32'h0);
    checkOutput("midreset_ready", 32'(fq_ready), 32'h1);
    fq_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0011, 32'h700, 1'b0, 1'b0);
    checkOutput("postreset_count", 32'(fq_count), 32'd2);
    checkOutput("postreset_pc_1", dec_pc_1, 32'h704);
    drainQueue();

    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
